conv_window_gen: RTL and testbench
==================================

// Module: conv_window_gen
// PURPOSE
//  Upstream stage of conv: turns a raster-order grayscale pixel stream into a 3x3 window.
//  Holds two line buffers plus a 3-column shift register per row.
//  Drives conv's row_R_C inputs as 13-bit signed values (zero-extended pixels), with a window-valid strobe.
//  One window per accepted pixel once two full rows and two columns are buffered. No border padding.
// PARAMETERS
//  IMG_WIDTH   640  pixels per line (>=3)
//  IMG_HEIGHT  480  lines per frame (>=3)
//  PIX_W       12   input pixel width (unsigned); window taps are PIX_W+1 bits signed
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous reset, active-high
//  pix_in      in   PIX_W    unsigned pixel, raster order
//  pix_valid   in   1        pix_in is accepted this cycle (no backpressure)
//  sof         in   1        start of frame; qualified by pix_valid; marks pixel (0,0)
//  row_R_C     out  PIX_W+1  nine taps, R,C in 0..2, signed; row 0 = oldest line, col 0 = oldest column
//  win_valid   out  1        row_* hold a complete new window this cycle
//  frame_done  out  1        1-cycle pulse after last pixel of frame accepted
//  busy        out  1        high in FILL or RUN
// BEHAVIOUR
//  - Reset: all row_* = 0, win_valid = 0, frame_done = 0, busy = 0, state = IDLE, counters = 0.
//    Line-buffer RAM contents are don't-care. Reset wins over every other input in the same cycle.
//  - States:
//    - IDLE: pixels without sof are ignored.
//    - IDLE -> FILL: on pix_valid & sof.
//    - FILL: row < 2. FILL -> RUN when row reaches 2.
//    - RUN: row >= 2. RUN -> IDLE after pixel (H-1, W-1) is accepted.
//  - Counters: col 0..W-1, row 0..H-1, advanced only on an accepted pixel.
//    col wraps to 0 and row increments when col == W-1.
//  - sof with pix_valid in any state restarts the frame: the pixel is (0,0), state = FILL.
//    Windows in flight are not emitted for the aborted frame.
//  - Accepted pixel p at (r,c):
//    - Read taps: t1 = lb1[c], t0 = lb0[c].
//    - Write: lb0[c] <= t1, lb1[c] <= p.
//    - Shift each window row left: row_R_0 <= row_R_1, row_R_1 <= row_R_2.
//    - New taps: row_0_2 <= t0, row_1_2 <= t1, row_2_2 <= {1'b0, p}.
//  - win_valid: registered, high the cycle after accepting a pixel with r >= 2 and c >= 2.
//    Latency is one clock, pixel to window. Windows per frame = (W-2)*(H-2).
//  - pix_valid low: everything holds; win_valid = 0 that cycle; row_* keep their last values.
//    Gaps may occur anywhere, including across line ends.
//  - frame_done: asserted in the same cycle as the final win_valid, which belongs to pixel (H-1, W-1).
//  - Taps are always non-negative (MSB = 0). Line buffers are PIX_W wide.
//  - busy drops in the same cycle frame_done rises.
// TESTING (bench: IMG_WIDTH=8, IMG_HEIGHT=6, PIX_W=12)
//  - Reset: hold rst 2 cycles mid-stream -> all row_* = 0, win_valid = 0, busy = 0;
//    pixels without sof are ignored afterwards.
//  - Ramp frame: pix = r*16 + c, continuous valid.
//    - First win_valid follows pixel (2,2), with row_0_0=0x000, row_1_1=0x011, row_2_2=0x022.
//    - Exactly 24 win_valid pulses. frame_done coincides with the last one, whose row_2_2 = 0x057.
//  - Gapped stream: same ramp with pix_valid toggled 1,0,1,0 -> identical 24 windows in order;
//    win_valid never high in a gap cycle.
//  - Max value: all pixels 0xFFF -> every tap = 13'h0FFF (positive).
//    Feeding conv, every window is uniform, so a Sobel output of 0 is expected.
//  - Restart: sof reasserted at pixel (3,4) -> no window from the old frame after that point.
//    The next win_valid follows new pixel (2,2); the frame completes with 24 windows.
//  - Back-to-back frames: sof on the cycle after frame_done -> no lost pixel; 48 windows total.

Source files
------------

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to 3x3 signed window using two line buffers
module conv_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PIX_W-1:0]        pix_in,
  input  logic                    pix_valid,
  input  logic                    sof,
  output logic signed [PIX_W:0]   row_0_0,
  output logic signed [PIX_W:0]   row_0_1,
  output logic signed [PIX_W:0]   row_0_2,
  output logic signed [PIX_W:0]   row_1_0,
  output logic signed [PIX_W:0]   row_1_1,
  output logic signed [PIX_W:0]   row_1_2,
  output logic signed [PIX_W:0]   row_2_0,
  output logic signed [PIX_W:0]   row_2_1,
  output logic signed [PIX_W:0]   row_2_2,
  output logic                    win_valid,
  output logic                    frame_done,
  output logic                    busy
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_C = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_HEIGHT - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]              r_state;
  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic                    r_win_valid;
  logic                    r_frame_done;
  logic signed [PIX_W:0]   r_win [3][3];
  logic [PIX_W-1:0]        r_lb0 [IMG_WIDTH];
  logic [PIX_W-1:0]        r_lb1 [IMG_WIDTH];
  logic                    w_acc;
  logic                    w_eol;
  logic                    w_last;
  logic [CW-1:0]           w_col;
  logic [RW-1:0]           w_row;
  logic [PIX_W-1:0]        w_t0;
  logic [PIX_W-1:0]        w_t1;

  // Position of the pixel being accepted; sof forces it to (0,0) in any state
  always_comb begin
    w_acc  = pix_valid && (sof || r_state != IDLE);
    w_col  = sof ? '0 : r_col;
    w_row  = sof ? '0 : r_row;
    w_eol  = w_col == LAST_C;
    w_last = w_eol && w_row == LAST_R;
    w_t0   = r_lb0[w_col];
    w_t1   = r_lb1[w_col];
  end

  // Line buffers: older line moves up into lb0, newest pixel lands in lb1
  always_ff @(posedge clk) begin
    if (!rst && w_acc) begin
      r_lb0[w_col] <= w_t1;
      r_lb1[w_col] <= pix_in;
    end
  end

  // Counters, FSM, window shift and output strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_win[i][j] <= '0;
    end else begin
      r_win_valid  <= w_acc && w_row >= RW'(2) && w_col >= CW'(2);
      r_frame_done <= w_acc && w_last;
      if (w_acc) begin
        r_col   <= w_eol ? '0 : w_col + 1'b1;
        r_row   <= w_last ? '0 : (w_eol ? w_row + 1'b1 : w_row);
        r_state <= w_last ? IDLE : ((w_eol && w_row >= RW'(1)) || w_row >= RW'(2)) ? RUN : FILL;
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= {1'b0, w_t0};
        r_win[1][2] <= {1'b0, w_t1};
        r_win[2][2] <= {1'b0, pix_in};
      end
    end
  end

  assign row_0_0    = r_win[0][0];
  assign row_0_1    = r_win[0][1];
  assign row_0_2    = r_win[0][2];
  assign row_1_0    = r_win[1][0];
  assign row_1_1    = r_win[1][1];
  assign row_1_2    = r_win[1][2];
  assign row_2_0    = r_win[2][0];
  assign row_2_1    = r_win[2][1];
  assign row_2_2    = r_win[2][2];
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed checks of the 3x3 window generator on an 8x6 image
module tb_conv_window_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic [12:0] r00, r01, r02, r10, r11, r12, r20, r21, r22;
  logic        win_valid, frame_done, busy;
  logic [12:0] tap [3][3];
  int          checks = 0;
  int          errors = 0;
  int          nwin;

  conv_window_gen #(.IMG_WIDTH(8), .IMG_HEIGHT(6), .PIX_W(12)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .row_0_0(r00), .row_0_1(r01), .row_0_2(r02),
    .row_1_0(r10), .row_1_1(r11), .row_1_2(r12),
    .row_2_0(r20), .row_2_1(r21), .row_2_2(r22),
    .win_valid(win_valid), .frame_done(frame_done), .busy(busy)
  );

  assign tap[0][0] = r00;
  assign tap[0][1] = r01;
  assign tap[0][2] = r02;
  assign tap[1][0] = r10;
  assign tap[1][1] = r11;
  assign tap[1][2] = r12;
  assign tap[2][0] = r20;
  assign tap[2][1] = r21;
  assign tap[2][2] = r22;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [11:0] p, input logic s, input logic v);
    pix_in = p;
    sof = s;
    pix_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("rst_tap_%0d_%0d", i, j), 32'(tap[i][j]), 0);
    chk("rst_win_valid", 32'(win_valid), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  // Ramp frame pix = r*16+c from (0,0) up to (but excluding) (sr,sc)
  task automatic ramp(input bit gap, input int sr, input int sc);
    bit last;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++) begin
        if (r == sr && c == sc) return;
        last = (r == 5 && c == 7);
        feed(12'(r * 16 + c), r == 0 && c == 0, 1'b1);
        chk($sformatf("win_valid_%0d_%0d", r, c), 32'(win_valid), 32'(r >= 2 && c >= 2));
        if (r >= 2 && c >= 2) begin
          nwin++;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              chk($sformatf("tap%0d%0d_at_%0d_%0d", i, j, r, c), 32'(tap[i][j]),
                  32'((r - 2 + i) * 16 + (c - 2 + j)));
        end
        chk($sformatf("frame_done_%0d_%0d", r, c), 32'(frame_done), 32'(last));
        chk($sformatf("busy_%0d_%0d", r, c), 32'(busy), 32'(!last));
        if (gap && !last) begin
          feed(12'hABC, 1'b0, 1'b0);
          chk("gap_win_valid", 32'(win_valid), 0);
          chk("gap_busy", 32'(busy), 1);
        end
      end
  endtask

  initial begin
    int gx, gy;
    feed(12'h0, 1'b0, 1'b0);
    feed(12'h0, 1'b0, 1'b0);
    rst = 1'b0;
    chk_reset_state();

    // Reset mid-stream, with sof/valid asserted during reset
    nwin = 0;
    ramp(1'b0, 3, 4);
    chk("partial_windows", 32'(nwin), 8);
    rst = 1'b1;
    feed(12'h5, 1'b1, 1'b1);
    feed(12'h6, 1'b1, 1'b1);
    rst = 1'b0;
    chk_reset_state();
    for (int k = 0; k < 20; k++) begin
      feed(12'(k + 1), 1'b0, 1'b1);
      chk("idle_win_valid", 32'(win_valid), 0);
      chk("idle_busy", 32'(busy), 0);
    end

    // Continuous ramp frame
    nwin = 0;
    ramp(1'b0, 6, 0);
    chk("ramp_windows", 32'(nwin), 24);
    chk("ramp_last_r22", 32'(r22), 32'h057);

    // Gapped ramp frame
    nwin = 0;
    ramp(1'b1, 6, 0);
    chk("gap_windows", 32'(nwin), 24);

    // All-max frame: taps stay positive, Sobel of a uniform window is zero
    nwin = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++) begin
        feed(12'hFFF, r == 0 && c == 0, 1'b1);
        chk("max_win_valid", 32'(win_valid), 32'(r >= 2 && c >= 2));
        if (r >= 2 && c >= 2) begin
          nwin++;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              chk("max_tap", 32'(tap[i][j]), 32'h0FFF);
          gx = (int'(r02) + 2 * int'(r12) + int'(r22)) - (int'(r00) + 2 * int'(r10) + int'(r20));
          gy = (int'(r20) + 2 * int'(r21) + int'(r22)) - (int'(r00) + 2 * int'(r01) + int'(r02));
          chk("max_sobel_gx", 32'(gx), 0);
          chk("max_sobel_gy", 32'(gy), 0);
        end
      end
    chk("max_windows", 32'(nwin), 24);
    chk("max_frame_done", 32'(frame_done), 1);

    // Restart: sof at the position of pixel (3,4)
    nwin = 0;
    ramp(1'b0, 3, 4);
    chk("restart_old_windows", 32'(nwin), 8);
    nwin = 0;
    ramp(1'b0, 6, 0);
    chk("restart_new_windows", 32'(nwin), 24);

    // Back-to-back frames
    nwin = 0;
    ramp(1'b0, 6, 0);
    ramp(1'b0, 6, 0);
    chk("b2b_windows", 32'(nwin), 48);
    feed(12'h0, 1'b0, 1'b0);
    chk("b2b_idle_busy", 32'(busy), 0);
    chk("b2b_idle_done", 32'(frame_done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
